imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_pkg.sv | 19 +
 rtl/rr_arb2.sv | 39 +++
 rtl/imem_arbiter.sv | 131 +++++++++++++
 tb/tb_imem_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
// Optional debug/loader port is enabled by defining IMEM_ARB_DBG_EN.
package imem_pkg;

    localparam int          DEPTH    = 256;
    localparam logic [31:0] ADDR_MAX = 32'h0000_03FF;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RESP_IF  = 2'd1,
        S_RESP_DBG = 2'd2
    } state_t;

    typedef enum logic {
        PORT_IF  = 1'b0,
        PORT_DBG = 1'b1
    } port_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on contention the port not granted last wins.
// Grants are combinational and forced low while reset is asserted.
module rr_arb2
    import imem_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req_if,
    input  logic i_req_dbg,
    output logic o_gnt_if,
    output logic o_gnt_dbg
);

    port_t r_last;

    always_comb begin
        o_gnt_if  = 1'b0;
        o_gnt_dbg = 1'b0;
        if (i_rst_n) begin
            if (i_req_if && (!i_req_dbg || r_last == PORT_DBG)) begin
                o_gnt_if = 1'b1;
            end else if (i_req_dbg) begin
                o_gnt_dbg = 1'b1;
            end
        end
    end

    // Reset marks debug as last-granted so fetch wins the first contention.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= PORT_DBG;
        end else if (o_gnt_if) begin
            r_last <= PORT_IF;
        end else if (o_gnt_dbg) begin
            r_last <= PORT_DBG;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates fetch and debug/loader accesses onto one single-port instruction memory.
// Debug port is functional only when IMEM_ARB_DBG_EN is defined; otherwise it is inert.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int          DEPTH    = imem_pkg::DEPTH,
    parameter logic [31:0] ADDR_MAX = imem_pkg::ADDR_MAX
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_if_req,
    input  logic [31:0]              i_if_addr,
    output logic                     o_if_gnt,
    output logic                     o_if_rvalid,
    output logic [31:0]              o_if_rdata,
    output logic                     o_if_err,
    input  logic                     i_dbg_req,
    input  logic                     i_dbg_we,
    input  logic [31:0]              i_dbg_addr,
    input  logic [31:0]              i_dbg_wdata,
    output logic                     o_dbg_gnt,
    output logic                     o_dbg_rvalid,
    output logic [31:0]              o_dbg_rdata,
    output logic                     o_dbg_err,
    output logic                     o_mem_en,
    output logic                     o_mem_we,
    output logic [$clog2(DEPTH)-1:0] o_mem_addr,
    output logic [31:0]              o_mem_wdata,
    input  logic [31:0]              i_mem_rdata,
    output state_t                   o_fsm_state
);

    localparam int AW = $clog2(DEPTH);

    logic        w_dbg_req;
    logic        w_dbg_we;
    logic        w_gnt_if;
    logic        w_gnt_dbg;
    logic        w_gnt;
    logic [31:0] w_addr;
    logic        w_legal;
    logic [31:0] w_resp_data;
    state_t      w_state_nxt;
    state_t      r_state;
    logic        r_resp_err;
    logic        r_resp_wr;

`ifdef IMEM_ARB_DBG_EN
    assign w_dbg_req   = i_dbg_req;
    assign w_dbg_we    = i_dbg_we;
    assign o_mem_wdata = i_dbg_wdata;
`else
    logic w_unused_dbg;
    assign w_unused_dbg = ^{i_dbg_req, i_dbg_we, i_dbg_wdata};
    assign w_dbg_req    = 1'b0;
    assign w_dbg_we     = 1'b0;
    assign o_mem_wdata  = 32'd0;
`endif

    rr_arb2 u_rr_arb2 (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req_if  (i_if_req),
        .i_req_dbg (w_dbg_req),
        .o_gnt_if  (w_gnt_if),
        .o_gnt_dbg (w_gnt_dbg)
    );

    assign w_gnt     = w_gnt_if | w_gnt_dbg;
    assign o_if_gnt  = w_gnt_if;
    assign o_dbg_gnt = w_gnt_dbg;

    assign w_addr  = w_gnt_dbg ? i_dbg_addr : i_if_addr;
    assign w_legal = (w_addr <= ADDR_MAX) && (w_addr[1:0] == 2'b00);

    // Illegal accesses are still granted but never reach the memory.
    assign o_mem_en   = w_gnt & w_legal;
    assign o_mem_we   = w_gnt_dbg & w_dbg_we & w_legal;
    assign o_mem_addr = w_addr[AW+1:2];

    always_comb begin
        w_state_nxt = S_IDLE;
        if (w_gnt_if) begin
            w_state_nxt = S_RESP_IF;
        end else if (w_gnt_dbg) begin
            w_state_nxt = S_RESP_DBG;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_resp_err <= 1'b0;
            r_resp_wr  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_resp_err <= w_gnt & ~w_legal;
            r_resp_wr  <= o_mem_we;
        end
    end

    // Errors and write acks return zero data instead of the memory output.
    assign w_resp_data = (r_resp_err || r_resp_wr) ? 32'd0 : i_mem_rdata;

    always_comb begin
        o_if_rvalid  = 1'b0;
        o_if_rdata   = 32'd0;
        o_if_err     = 1'b0;
        o_dbg_rvalid = 1'b0;
        o_dbg_rdata  = 32'd0;
        o_dbg_err    = 1'b0;
        case (r_state)
            S_RESP_IF: begin
                o_if_rvalid = 1'b1;
                o_if_rdata  = w_resp_data;
                o_if_err    = r_resp_err;
            end
`ifdef IMEM_ARB_DBG_EN
            S_RESP_DBG: begin
                o_dbg_rvalid = 1'b1;
                o_dbg_rdata  = w_resp_data;
                o_dbg_err    = r_resp_err;
            end
`endif
            default: ;
        endcase
    end

    assign o_fsm_state = r_state;

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized scoreboard bench for imem_arbiter with a behavioural memory/arbitration model.
// Debug-port expectations follow whether IMEM_ARB_DBG_EN is defined for the build.
module tb_imem_arbiter;

    localparam int          DEPTH    = 256;
    localparam logic [31:0] ADDR_MAX = 32'h0000_03FF;
    localparam int          W        = 50;
`ifdef IMEM_ARB_DBG_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_if_req = 1'b0;
    logic [31:0] i_if_addr = 32'd0;
    logic        i_dbg_req = 1'b0;
    logic        i_dbg_we = 1'b0;
    logic [31:0] i_dbg_addr = 32'd0;
    logic [31:0] i_dbg_wdata = 32'd0;
    logic        o_if_gnt, o_if_rvalid, o_if_err;
    logic [31:0] o_if_rdata;
    logic        o_dbg_gnt, o_dbg_rvalid, o_dbg_err;
    logic [31:0] o_dbg_rdata;
    logic        o_mem_en, o_mem_we;
    logic [7:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata = 32'd0;
    logic [1:0]  o_fsm_state;

    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    imem_arbiter #(.DEPTH(DEPTH), .ADDR_MAX(ADDR_MAX)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_if_req     (i_if_req),
        .i_if_addr    (i_if_addr),
        .o_if_gnt     (o_if_gnt),
        .o_if_rvalid  (o_if_rvalid),
        .o_if_rdata   (o_if_rdata),
        .o_if_err     (o_if_err),
        .i_dbg_req    (i_dbg_req),
        .i_dbg_we     (i_dbg_we),
        .i_dbg_addr   (i_dbg_addr),
        .i_dbg_wdata  (i_dbg_wdata),
        .o_dbg_gnt    (o_dbg_gnt),
        .o_dbg_rvalid (o_dbg_rvalid),
        .o_dbg_rdata  (o_dbg_rdata),
        .o_dbg_err    (o_dbg_err),
        .o_mem_en     (o_mem_en),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata),
        .o_fsm_state  (o_fsm_state)
    );

    // ---------------- clock / watchdog ----------------
    initial forever #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'h11;
            1:       return 32'h22;
            2:       return 32'h33;
            default: return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- memory environment ----------------
    logic [31:0] env_mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) env_mem[i] = init_word(i);
        forever begin
            @(posedge i_clk);
            if (o_mem_en) begin
                if (o_mem_we) env_mem[o_mem_addr] <= o_mem_wdata;
                else          i_mem_rdata <= env_mem[o_mem_addr];
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic rq_if, input logic [31:0] a_if, input logic rq_dbg,
                         input logic we, input logic [31:0] a_dbg, input logic [31:0] wd);
        i_if_req    = rq_if;
        i_if_addr   = a_if;
        i_dbg_req   = rq_dbg;
        i_dbg_we    = we;
        i_dbg_addr  = a_dbg;
        i_dbg_wdata = wd;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        idle(3);
        i_rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] w;
        w = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        case ($urandom_range(0, 9))
            0:       return w | 32'($urandom_range(1, 3));
            1:       return 32'h400 + 32'($urandom_range(0, 4095));
            2:       return $urandom();
            default: return w;
        endcase
    endfunction

    initial begin
        #2;
        do_reset();
        // contention straight after reset: fetch first, then alternate
        for (int i = 0; i < 4; i++) drive(1'b1, 32'(4 * i), 1'b1, 1'b0, 32'(64 + 4 * i), 32'd0);
        idle(2);
        // back-to-back fetch of preloaded words
        drive(1'b1, 32'h000, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 32'h004, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 32'h008, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(2);
        // debug write then fetch read of the same word
        drive(1'b0, 32'd0, 1'b1, 1'b1, 32'h010, 32'hDEAD_BEEF);
        drive(1'b1, 32'h010, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(2);
        // illegal addresses and the legal upper boundary
        drive(1'b1, 32'h400, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'h002, 32'd0);
        drive(1'b1, 32'h3FC, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 32'h3FD, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(2);
        // reset in the cycle after a grant drops the pending response
        drive(1'b1, 32'h020, 1'b0, 1'b0, 32'd0, 32'd0);
        i_rst_n = 1'b0;
        drive(1'b1, 32'h024, 1'b1, 1'b0, 32'h028, 32'd0);
        drive(1'b1, 32'h024, 1'b1, 1'b0, 32'h028, 32'd0);
        i_rst_n = 1'b1;
        drive(1'b1, 32'h024, 1'b1, 1'b0, 32'h028, 32'd0);
        drive(1'b1, 32'h02C, 1'b1, 1'b0, 32'h030, 32'd0);
        idle(2);
        // randomized traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            i_rst_n = ($urandom_range(0, 79) != 0);
            drive(($urandom_range(0, 3) != 0), rand_addr(), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 2) == 0), rand_addr(), $urandom());
        end
        i_rst_n = 1'b1;
        idle(4);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // ---------------- reference model + monitor ----------------
    logic [31:0] ref_mem [DEPTH];
    logic        m_last_dbg;
    logic [15:0] cyc;

    initial begin
        logic [W-1:0] e;
        logic         e_port, eff_dbg, gi, gd, legal, wr;
        logic [31:0]  a, data;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        m_last_dbg = 1'b1;
        cyc = 16'd0;
        forever begin
            @(negedge i_clk);
            cyc = cyc + 16'd1;
            if (!i_rst_n) begin
                check("rst_ctrl_zero", {o_if_gnt, o_dbg_gnt, o_mem_en, o_if_rvalid, o_if_err,
                                        o_dbg_rvalid, o_dbg_err}, 64'd0);
                check("rst_rdata_zero", {o_if_rdata, o_dbg_rdata}, 64'd0);
                exp_q.delete();
                m_last_dbg = 1'b1;
            end else begin
                // response side
                if (o_if_rvalid || o_dbg_rvalid) begin
                    if (exp_q.size() == 0) begin
                        check("rvalid_unexpected", {o_if_rvalid, o_dbg_rvalid}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        e_port = e[33];
                        check("resp_port", {o_if_rvalid, o_dbg_rvalid}, e_port ? 2'b01 : 2'b10);
                        check("resp_cycle", cyc, e[49:34]);
                        check("resp_rdata", e_port ? o_dbg_rdata : o_if_rdata, e[31:0]);
                        check("resp_err", e_port ? o_dbg_err : o_if_err, e[32]);
                        check("other_port_zero", e_port ? {o_if_rdata, o_if_err}
                                                        : {o_dbg_rdata, o_dbg_err}, 64'd0);
                    end
                end else begin
                    if (exp_q.size() > 0 && exp_q[0][49:34] <= cyc) begin
                        check("rvalid_missing", 64'd0, 64'd1);
                        void'(exp_q.pop_front());
                    end
                    check("idle_if_zero", {o_if_rdata, o_if_err}, 64'd0);
                    check("idle_dbg_zero", {o_dbg_rdata, o_dbg_err}, 64'd0);
                end
                // request side: single requester wins, contention goes to the other port
                eff_dbg = DBG_EN && i_dbg_req;
                if (i_if_req && eff_dbg) begin
                    gd = !m_last_dbg;
                    gi = m_last_dbg;
                end else begin
                    gi = i_if_req;
                    gd = eff_dbg;
                end
                check("gnt", {o_if_gnt, o_dbg_gnt}, {gi, gd});
                if (!DBG_EN) check("mem_we_off", o_mem_we, 64'd0);
                if (gi || gd) begin
                    a     = gd ? i_dbg_addr : i_if_addr;
                    legal = (a <= ADDR_MAX) && (a % 4 == 0);
                    wr    = gd && i_dbg_we;
                    check("mem_en", o_mem_en, legal);
                    data = 32'd0;
                    if (legal) begin
                        check("mem_addr", o_mem_addr, a / 4);
                        check("mem_we", o_mem_we, wr);
                        if (wr) begin
                            check("mem_wdata", o_mem_wdata, i_dbg_wdata);
                            ref_mem[a / 4] = i_dbg_wdata;
                        end else begin
                            data = ref_mem[a / 4];
                        end
                    end
                    exp_q.push_back({cyc + 16'd1, gd, !legal, data});
                    m_last_dbg = gd;
                end else begin
                    check("mem_en_idle", o_mem_en, 64'd0);
                end
            end
        end
    end

endmodule
